// File: rtl/usb_packet_rx.sv
// USB packet receiver: hunts SYNC on the unstuffed bit stream, assembles LSB-first
// bytes, checks PID/CRC5/CRC16 and flags packet-level errors at end of packet.
module usb_packet_rx #(
  parameter int unsigned SYNC_MIN_ZEROS = 6
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_data,
  input  logic       i_valid,
  input  logic       i_error,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_sop,
  output logic [3:0] o_pid,
  output logic       o_eop,
  output logic       o_pid_err,
  output logic       o_crc_err,
  output logic       o_stuff_err,
  output logic       o_align_err
);

  typedef enum logic [1:0] {IDLE, PID, PAYLOAD, DONE} state_t;

  localparam logic [2:0] MIN_ZEROS = 3'(SYNC_MIN_ZEROS);

  state_t      state;
  logic        gap_prev;
  logic        eol;
  logic [2:0]  zero_cnt;
  logic [2:0]  bit_cnt;
  logic [6:0]  shift;
  logic [7:0]  next_byte;
  logic [9:0]  byte_cnt;
  logic [4:0]  crc5;
  logic [4:0]  crc5_next;
  logic [15:0] crc16;
  logic [15:0] crc16_next;
  logic        pid_err;
  logic        stuff_seen;
  logic        align_bad;
  logic        crc_bad;

  assign eol        = !i_valid && gap_prev;
  assign next_byte  = {i_data, shift};
  assign crc5_next  = {crc5[3:0], 1'b0} ^ ((crc5[4] ^ i_data) ? 5'b00101 : 5'b00000);
  assign crc16_next = {crc16[14:0], 1'b0} ^ ((crc16[15] ^ i_data) ? 16'h8005 : 16'h0000);
  assign align_bad  = bit_cnt != 3'd0;

  always_comb begin
    crc_bad = 1'b0;
    if (!pid_err && !align_bad) begin
      case (o_pid[1:0])
        2'b01:   crc_bad = (byte_cnt != 10'd2) || (crc5 != 5'b01100);
        2'b11:   crc_bad = (byte_cnt < 10'd2) || (crc16 != 16'h800D);
        2'b10:   crc_bad = byte_cnt != 10'd0;
        default: crc_bad = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state        <= IDLE;
      gap_prev     <= 1'b0;
      zero_cnt     <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      byte_cnt     <= '0;
      crc5         <= '0;
      crc16        <= '0;
      pid_err      <= 1'b0;
      stuff_seen   <= 1'b0;
      o_byte       <= '0;
      o_byte_valid <= 1'b0;
      o_sop        <= 1'b0;
      o_pid        <= '0;
      o_eop        <= 1'b0;
      o_pid_err    <= 1'b0;
      o_crc_err    <= 1'b0;
      o_stuff_err  <= 1'b0;
      o_align_err  <= 1'b0;
    end else begin
      gap_prev     <= !i_valid;
      o_byte_valid <= 1'b0;
      o_sop        <= 1'b0;
      o_eop        <= 1'b0;
      o_pid_err    <= 1'b0;
      o_crc_err    <= 1'b0;
      o_stuff_err  <= 1'b0;
      o_align_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid) begin
            if (!i_data) begin
              if (zero_cnt != 3'd7) zero_cnt <= zero_cnt + 3'd1;
            end else begin
              if (zero_cnt >= MIN_ZEROS) begin
                state      <= PID;
                bit_cnt    <= '0;
                stuff_seen <= 1'b0;
              end
              zero_cnt <= '0;
            end
          end else if (eol) begin
            zero_cnt <= '0;
          end
        end
        PID: begin
          if (i_error) stuff_seen <= 1'b1;
          if (i_valid) begin
            shift   <= next_byte[7:1];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              o_byte       <= next_byte;
              o_byte_valid <= 1'b1;
              o_sop        <= 1'b1;
              o_pid        <= next_byte[3:0];
              pid_err      <= next_byte[7:4] != ~next_byte[3:0];
              byte_cnt     <= '0;
              crc5         <= '1;
              crc16        <= '1;
              state        <= PAYLOAD;
            end
          end else if (eol) begin
            state <= IDLE;
          end
        end
        PAYLOAD: begin
          if (i_error) stuff_seen <= 1'b1;
          if (i_valid) begin
            shift   <= next_byte[7:1];
            bit_cnt <= bit_cnt + 3'd1;
            crc5    <= crc5_next;
            crc16   <= crc16_next;
            if (bit_cnt == 3'd7) begin
              o_byte       <= next_byte;
              o_byte_valid <= 1'b1;
              if (byte_cnt != 10'd1023) byte_cnt <= byte_cnt + 10'd1;
            end
          end else if (eol) begin
            // Status is registered on the EOL edge so o_eop is high during DONE;
            // CRC is already final since the last valid bit is >= 2 cycles old.
            state       <= DONE;
            o_eop       <= 1'b1;
            o_pid_err   <= pid_err;
            o_align_err <= align_bad;
            o_crc_err   <= crc_bad;
            o_stuff_err <= stuff_seen || i_error;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_packet_rx.sv
// Directed bench for usb_packet_rx: a packet-level model predicts bytes and end-of-packet
// flags, and a per-cycle compare process checks the DUT against those predictions.
module tb_usb_packet_rx;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
  } byte_exp_t;

  typedef struct packed {
    logic pid_err;
    logic crc_err;
    logic stuff_err;
    logic align_err;
  } flags_t;

  logic       clk;
  logic       rst_n;
  logic       i_data;
  logic       i_valid;
  logic       i_error;
  logic [7:0] o_byte;
  logic       o_byte_valid;
  logic       o_sop;
  logic [3:0] o_pid;
  logic       o_eop;
  logic       o_pid_err;
  logic       o_crc_err;
  logic       o_stuff_err;
  logic       o_align_err;

  usb_packet_rx #(.SYNC_MIN_ZEROS(6)) dut (
    .i_clk        (clk),
    .i_rstn       (rst_n),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .i_error      (i_error),
    .o_byte       (o_byte),
    .o_byte_valid (o_byte_valid),
    .o_sop        (o_sop),
    .o_pid        (o_pid),
    .o_eop        (o_eop),
    .o_pid_err    (o_pid_err),
    .o_crc_err    (o_crc_err),
    .o_stuff_err  (o_stuff_err),
    .o_align_err  (o_align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packet description consumed by both the driver and the model.
  logic [7:0]  tx[$];
  int unsigned tx_extra;
  logic [7:0]  tx_extra_val;
  int unsigned tx_sync_zeros;
  int unsigned tx_hole_every;
  int          tx_err_bit;
  bit          tx_err_eol;
  int          tx_abort;

  byte_exp_t bq[$];
  flags_t    eq[$];
  int        n_tests = 0;
  int        n_fail  = 0;
  logic [3:0] exp_pid;
  logic [7:0] last_byte;
  byte_exp_t  ce;
  flags_t     cf;
  flags_t     pf;
  logic [7:0] b2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic defaults();
    tx = {};
    tx_extra = 0;
    tx_extra_val = 8'h00;
    tx_sync_zeros = 7;
    tx_hole_every = 0;
    tx_err_bit = -1;
    tx_err_eol = 1'b0;
    tx_abort = -1;
  endtask

  // Transmitted CRC5 field (bit j = j-th CRC bit on the wire) for 11 data bits.
  function automatic logic [4:0] crc5_field(input logic [10:0] d);
    logic [4:0] c;
    logic [4:0] f;
    c = '1;
    for (int unsigned k = 0; k < 11; k++)
      c = (c[4] ^ d[k]) ? ({c[3:0], 1'b0} ^ 5'b00101) : {c[3:0], 1'b0};
    for (int unsigned j = 0; j < 5; j++) f[j] = ~c[4 - j];
    return f;
  endfunction

  // Transmitted CRC16 bytes {second, first} for tx[first..last].
  function automatic logic [15:0] crc16_tail(input int unsigned first, input int unsigned last);
    logic [15:0] c;
    logic [15:0] t;
    logic [7:0]  b;
    c = '1;
    for (int unsigned i = first; i <= last; i++) begin
      b = tx[i];
      for (int unsigned k = 0; k < 8; k++)
        c = (c[15] ^ b[k]) ? ({c[14:0], 1'b0} ^ 16'h8005) : {c[14:0], 1'b0};
    end
    for (int unsigned j = 0; j < 16; j++) t[j] = ~c[15 - j];
    return t;
  endfunction

  function automatic flags_t model_flags();
    flags_t     f;
    int         n;
    logic [7:0] pid;
    logic [7:0] hi;
    logic [15:0] t;
    pid = tx[0];
    n = tx.size() - 1;
    f.pid_err   = pid[7:4] != ~pid[3:0];
    f.align_err = tx_extra != 0;
    f.stuff_err = (tx_err_bit >= 0) || tx_err_eol;
    f.crc_err   = 1'b0;
    if (!f.pid_err && !f.align_err) begin
      case (pid[1:0])
        2'b01: begin
          if (n != 2) f.crc_err = 1'b1;
          else begin
            hi = tx[2];
            f.crc_err = crc5_field({hi[2:0], tx[1]}) != hi[7:3];
          end
        end
        2'b11: begin
          if (n < 2) f.crc_err = 1'b1;
          else begin
            t = crc16_tail(1, n - 2);
            f.crc_err = t != {tx[n], tx[n - 1]};
          end
        end
        2'b10:   f.crc_err = n != 0;
        default: f.crc_err = 1'b0;
      endcase
    end
    return f;
  endfunction

  task automatic model_expect();
    int nfull;
    byte_exp_t e;
    if (tx_sync_zeros < 6) return;
    nfull = (tx_abort >= 0) ? tx_abort / 8 : tx.size();
    for (int i = 0; i < nfull && i < tx.size(); i++) begin
      e.data = tx[i];
      e.sop  = (i == 0);
      bq.push_back(e);
    end
    if (tx_abort < 0) eq.push_back(model_flags());
  endtask

  task automatic send();
    logic bits[$];
    int   sync_len;
    int   p;
    logic [7:0] b;
    model_expect();
    bits = {};
    for (int unsigned i = 0; i < tx_sync_zeros; i++) bits.push_back(1'b0);
    bits.push_back(1'b1);
    sync_len = bits.size();
    foreach (tx[i]) begin
      b = tx[i];
      for (int unsigned k = 0; k < 8; k++) bits.push_back(b[k]);
    end
    for (int unsigned k = 0; k < tx_extra; k++) bits.push_back(tx_extra_val[k]);
    repeat (3) tick();
    for (int unsigned k = 0; k < bits.size(); k++) begin
      p = int'(k) - sync_len;
      if (tx_abort >= 0 && p == tx_abort) break;
      tick();
      i_valid = 1'b1;
      i_data  = bits[k];
      i_error = (p >= 0) && (p == tx_err_bit);
      if (tx_hole_every != 0 && ((k + 1) % tx_hole_every) == 0) begin
        tick();
        i_valid = 1'b0;
        i_data  = 1'b0;
        i_error = 1'b0;
      end
    end
    tick();
    i_valid = 1'b0;
    i_data  = 1'b0;
    i_error = 1'b0;
    if (tx_abort >= 0) begin
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
    end else begin
      tick();
      i_error = tx_err_eol;
      tick();
      i_error = 1'b0;
    end
    repeat (6) tick();
    check("bytes_drained", 32'(bq.size()), 32'd0);
    check("eop_drained", 32'(eq.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs", 32'({o_byte, o_byte_valid, o_sop, o_pid, o_eop,
                                  o_pid_err, o_crc_err, o_stuff_err, o_align_err}), 32'd0);
      exp_pid   = 4'h0;
      last_byte = 8'h00;
    end else begin
      if (o_byte_valid) begin
        if (bq.size() == 0) check("unexpected_byte", 32'(o_byte_valid), 32'd0);
        else begin
          ce = bq.pop_front();
          check("byte", 32'(o_byte), 32'(ce.data));
          check("sop", 32'(o_sop), 32'(ce.sop));
          if (ce.sop) exp_pid = ce.data[3:0];
          last_byte = ce.data;
        end
      end else begin
        check("idle_hold", 32'({o_sop, o_byte}), 32'({1'b0, last_byte}));
      end
      check("pid", 32'(o_pid), 32'(exp_pid));
      if (o_eop) begin
        if (eq.size() == 0) check("unexpected_eop", 32'(o_eop), 32'd0);
        else begin
          cf = eq.pop_front();
          check("eop_flags", 32'({o_pid_err, o_crc_err, o_stuff_err, o_align_err}), 32'(cf));
          check("bytes_before_eop", 32'(bq.size()), 32'd0);
        end
      end else begin
        check("flags_idle", 32'({o_pid_err, o_crc_err, o_stuff_err, o_align_err}), 32'd0);
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_data  = 1'b0;
    i_error = 1'b0;
    exp_pid = 4'h0;
    last_byte = 8'h00;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Hand-computed pins for the model itself.
    defaults();
    check("pin_crc5_zero", 32'(crc5_field(11'h000)), 32'h02);
    check("pin_crc16_empty", 32'(crc16_tail(1, 0)), 32'h0000);
    tx = {8'h69, 8'h00, 8'h10};
    pf = model_flags();
    check("pin_in_token", 32'(pf), 32'b0000);
    tx = {8'hC3, 8'h00, 8'h01};
    pf = model_flags();
    check("pin_data0_bad", 32'(pf), 32'b0100);
    tx = {8'hD3};
    pf = model_flags();
    check("pin_bad_pid", 32'(pf), 32'b1000);

    // IN token
    defaults(); tx = {8'h69, 8'h00, 8'h10}; send();
    check("in_pid_literal", 32'(o_pid), 32'h9);
    // Zero-length DATA0, good and bad CRC
    defaults(); tx = {8'hC3, 8'h00, 8'h00}; send();
    check("data0_pid_literal", 32'(o_pid), 32'h3);
    defaults(); tx = {8'hC3, 8'h00, 8'h01}; send();
    // ACK, then corrupted PID
    defaults(); tx = {8'hD2}; send();
    check("ack_pid_literal", 32'(o_pid), 32'h2);
    defaults(); tx = {8'hD3}; send();
    // Stuffing holes, stuff error mid-payload and on the EOL cycle
    defaults(); tx = {8'h69, 8'h00, 8'h10}; tx_hole_every = 6; send();
    defaults(); tx = {8'h69, 8'h00, 8'h10}; tx_err_bit = 12; send();
    defaults(); tx = {8'h69, 8'h00, 8'h10}; tx_err_eol = 1'b1; send();
    // Trailing partial byte
    defaults(); tx = {8'h69, 8'h00, 8'h10}; tx_extra = 3; tx_extra_val = 8'h05; send();
    // Short SYNC ignored; SYNC with one lost leading zero accepted
    defaults(); tx = {8'hD2}; tx_sync_zeros = 5; send();
    defaults(); tx = {8'hD2}; tx_sync_zeros = 6; send();
    // Reset mid-payload, then a clean packet
    defaults(); tx = {8'hC3, 8'h11, 8'h22}; tx_abort = 19; send();
    check("pid_after_reset", 32'(o_pid), 32'h0);
    defaults(); tx = {8'h69, 8'h00, 8'h10}; send();
    // DATA1 with a generated CRC16, SOF with a generated CRC5
    defaults(); tx = {8'h4B, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    pf = 4'b0000;
    b2 = 8'h00;
    begin
      logic [15:0] t;
      t = crc16_tail(1, 4);
      tx.push_back(t[7:0]);
      tx.push_back(t[15:8]);
    end
    send();
    defaults(); tx = {8'hA5, 8'h23, {crc5_field(11'h123), 3'b001}}; send();
    // Length violations and special PID
    defaults(); tx = {8'h2D, 8'h00, 8'h10, 8'h00}; send();
    defaults(); tx = {8'hD2, 8'h55}; send();
    defaults(); tx = {8'h3C, 8'hAA, 8'h55}; send();
    defaults(); tx = {8'hC3, 8'h7E}; send();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_packet_rx.md
Name: usb_packet_rx

Overview:
- Consumes the unstuffed serial bit stream from the NRZI decode/bit-unstuff stage.
- Hunts for SYNC, then assembles bytes LSB-first and checks the PID.
- Validates CRC5 on token packets and CRC16 on data packets, and delimits the packet.
- Feeds byte-wide packet data and end-of-packet status to the USB protocol engine downstream.

Parameters:
SYNC_MIN_ZEROS, 6, minimum consecutive decoded 0 bits before the terminating 1 for SYNC to be accepted (tolerates one lost leading bit).

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_rstn  input  1  asynchronous active-low reset
i_data  input  1  decoded, unstuffed bit
i_valid  input  1  i_data qualifier; low for one cycle on a removed stuffed bit, low continuously after packet end
i_error  input  1  upstream bit-stuff violation (7+ consecutive 1s)
o_byte  output  8  received byte (PID, payload, CRC bytes)
o_byte_valid  output  1  one-cycle qualifier for o_byte
o_sop  output  1  high with o_byte_valid on the PID byte only
o_pid  output  4  PID[3:0] of current packet; held from sop until next sop
o_eop  output  1  one-cycle end-of-packet pulse; the error flags below are meaningful only while o_eop=1
o_pid_err  output  1  PID[7:4] != ~PID[3:0]
o_crc_err  output  1  CRC residual mismatch or illegal length
o_stuff_err  output  1  i_error seen during packet
o_align_err  output  1  packet bit count not a multiple of 8

Behaviour:
- Reset: state IDLE, all counters and shift/CRC registers cleared. All outputs 0, including o_byte=0x00 and o_pid=0x0. Reset mid-packet abandons the packet with no o_eop.
- Gap rule: one cycle of i_valid=0 is a stuffed-bit hole and is ignored; state and counts are unchanged. Two consecutive i_valid=0 cycles are end-of-line (EOL).
- IDLE/HUNT:
  - Count consecutive valid 0s, saturating at 7.
  - A valid 1 with count >= SYNC_MIN_ZEROS goes to PID; the bit count is cleared.
  - A valid 1 with fewer zeros clears the count.
  - EOL clears the count.
  - i_error is ignored.
- PID:
  - Shift bits LSB-first.
  - On the 8th valid bit: register the byte, then one cycle later assert o_byte_valid=1 and o_sop=1, and update o_pid.
  - Set pid_err if PID[7:4] != ~PID[3:0]; go to PAYLOAD.
  - EOL inside PID returns to IDLE silently (no sop, no eop).
- PAYLOAD:
  - Each 8th valid bit produces o_byte_valid one cycle later.
  - Byte count saturates at 1023.
  - CRC engines update per valid bit, starting with the first bit after PID.
    - CRC5: poly x^5+x^2+1, init 5'b11111, good residual 5'b01100.
    - CRC16: poly 0x8005, init 0xFFFF, good residual 0x800D.
  - EOL goes to DONE.
- DONE (one cycle): assert o_eop with flags:
  - stuff_err: i_error seen in PID/PAYLOAD, sticky for the packet.
  - align_err: residual bit count != 0. Partial bits are discarded and no byte is emitted.
  - pid_err: as computed in PID.
  - crc_err, evaluated only if pid_err=0 and align_err=0:
    - Token PID[1:0]=01: crc_err if payload byte count != 2 or CRC5 residual bad.
    - Data PID[1:0]=11: crc_err if payload byte count < 2 or CRC16 residual bad.
    - Handshake PID[1:0]=10: crc_err if payload byte count != 0.
    - Special PID[1:0]=00: crc_err forced 0.
  - Then return to IDLE.
- Simultaneous events:
  - The 8th bit arriving in the cycle before EOL is counted normally.
  - i_error concurrent with EOL is still captured.
  - o_byte_valid for the last byte precedes o_eop by >= 1 cycle.
- Between packets, o_byte holds its last value and o_byte_valid, o_sop and o_eop stay 0.
- Flags are 0 whenever o_eop=0.

Test Plan:
1. IN token: SYNC 0000_0001, then bytes 0x69,0x00,0x10, then 2 idle cycles -> bytes 69/00/10 emitted with sop on 69, o_pid=0x9, o_eop=1 with all flags 0.
2. Zero-length DATA0: bytes 0xC3,0x00,0x00 -> o_pid=0x3, o_eop with crc_err=0. Repeat with last byte 0x01 -> crc_err=1.
3. ACK 0xD2 alone -> o_pid=0x2, eop, flags 0. PID 0xD3 -> pid_err=1, crc_err=0.
4. Stuffing holes: IN token with a single-cycle i_valid=0 inserted after every 6th bit -> identical output to scenario 1. Assert i_error for one cycle mid-payload -> stuff_err=1 at eop.
5. Token followed by 3 extra bits then EOL -> align_err=1, no 4th byte, crc_err=0.
6. SYNC with only 5 zeros -> no sop. Assert reset mid-payload -> no eop, outputs 0. A following valid packet is received correctly.
